// File: rtl/da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic FIR:
// coefficient constants, LUT width and FSM state encoding.
package da_pkg;

  // Width of one LUT entry; the largest entry (sum of all taps) is 10.
  localparam int LUT_W = 5;

  // Filter taps: y[n] = C0*x[n] + C1*x[n-1] + C2*x[n-2] + C3*x[n-3]
  localparam logic signed [LUT_W-1:0] C0 = 5'sd2;
  localparam logic signed [LUT_W-1:0] C1 = 5'sd3;
  localparam logic signed [LUT_W-1:0] C2 = 5'sd1;
  localparam logic signed [LUT_W-1:0] C3 = 5'sd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/da_serial_fir_if.sv
// Sample-in / result-out bus of the serial DA FIR.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds data and valid
// stable until that edge; ready may be driven independently of valid.
interface da_serial_fir_if #(
  parameter int W  = 8,
  parameter int OW = 13
);
  logic signed [W-1:0]  x_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [OW-1:0] y;
  logic                 out_valid;
  logic                 out_ready;

  // Sample source / result sink side.
  modport master (
    output x_in, in_valid, out_ready,
    input  in_ready, y, out_valid
  );

  // Filter side.
  modport slave (
    input  x_in, in_valid, out_ready,
    output in_ready, y, out_valid
  );
endinterface

// File: rtl/da_lut4.sv
// Distributed-arithmetic lookup: each address bit selects one filter tap
// and the output is the sum of the selected coefficients (0..10).
module da_lut4
  import da_pkg::*;
(
  input  logic [3:0]              addr_i,
  output logic signed [LUT_W-1:0] val_o
);

  // Sum the taps whose delay-line bit is set in this bit-plane.
  always_comb begin
    val_o = '0;
    if (addr_i[0]) val_o = val_o + C0;
    if (addr_i[1]) val_o = val_o + C1;
    if (addr_i[2]) val_o = val_o + C2;
    if (addr_i[3]) val_o = val_o + C3;
  end

endmodule

// File: rtl/da_serial_fir.sv
// Bit-serial 4-tap DA FIR. One sample is accepted in IDLE, then W bit-planes
// are walked MSB first through a shared LUT, Horner style: the sign plane is
// subtracted, every following plane is added after doubling the accumulator.
// The exact result is then held in DONE until the sink takes it.
module da_serial_fir
  import da_pkg::*;
#(
  parameter int W  = 8,
  parameter int OW = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  da_serial_fir_if.slave       bus,
  output state_t               state_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic signed [W-1:0]  x_q [4];
  logic signed [W-1:0]  x_d [4];
  logic signed [OW-1:0] acc_q, acc_d, acc_next;
  logic signed [OW-1:0] y_q, y_d;
  logic                 out_valid_q, out_valid_d;

  logic [3:0]              lut_addr;
  logic signed [LUT_W-1:0] lut_val;
  logic signed [OW-1:0]    lut_ext;

  // Current bit-plane across the four taps; bit0 is the newest sample.
  assign lut_addr = {x_q[3][bitcnt_q], x_q[2][bitcnt_q],
                     x_q[1][bitcnt_q], x_q[0][bitcnt_q]};

  da_lut4 u_lut (
    .addr_i (lut_addr),
    .val_o  (lut_val)
  );

  assign lut_ext  = OW'(lut_val);
  // The sign plane carries weight -2^(W-1), so it starts the sum negated.
  assign acc_next = (bitcnt_q == CW'(W - 1)) ? -lut_ext : (acc_q <<< 1) + lut_ext;

  // Next-state and datapath update for IDLE -> CALC -> DONE.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    x_d         = x_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d[0]   = bus.x_in;
          x_d[1]   = x_q[0];
          x_d[2]   = x_q[1];
          x_d[3]   = x_q[2];
          bitcnt_d = CW'(W - 1);
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        if (bitcnt_q == '0) begin
          y_d         = acc_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          bitcnt_d = bitcnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight result and the tap history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign state_o       = state_q;

endmodule
